// File: rtl/tri_bus_arbiter_if.sv
// Request/grant bundle between the bus requesters and the tri-state arbiter.
// The arbiter side uses the slave modport; requesters use master.
interface tri_bus_arbiter_if #(
   parameter int M = 4
);
   logic [M-1:0]         req;
   logic [M-1:0]         gnt;
   logic [$clog2(M)-1:0] owner;
   logic                 busy;

   modport master (
      output req,
      input  gnt,
      input  owner,
      input  busy
   );

   modport slave (
      input  req,
      output gnt,
      output owner,
      output busy
   );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin one-hot enable generator for a shared tri-state bus.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles.
module tri_bus_arbiter #(
   parameter int N        = 3,
   parameter int M        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   tri_bus_arbiter_if.slave bus
);
   localparam int PW = $clog2(M);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      TURN
   } state_e;

   state_e        state_q, state_d;
   logic [M-1:0]  gnt_q, gnt_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] win;
   logic [PW:0]   idx;
   logic          busy_q, busy_d;
   logic          any_req;
   logic          timeout;
   logic          release_c;

   if (M < 2 || N < 1 || MAX_HOLD < 1) begin : g_param_chk
      $error("tri_bus_arbiter: illegal parameters");
   end

   assign any_req = |bus.req;

   // Lowest offset from ptr wins; scanning downward lets it overwrite last.
   always_comb begin
      win = ptr_q;
      idx = '0;
      for (int i = M - 1; i >= 0; i--) begin
         idx = {1'b0, ptr_q} + (PW+1)'(i);
         if (idx >= (PW+1)'(M)) idx = idx - (PW+1)'(M);
         if (bus.req[idx]) win = idx[PW-1:0];
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign timeout = (cnt_q == CW'(MAX_HOLD));

   always_comb begin
      cnt_d = '0;
      if (state_d == GRANT) begin
         cnt_d = (state_q == GRANT) ? cnt_q + CW'(1) : CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      busy_d    = busy_q;
      release_c = 1'b0;
      unique case (state_q)
         GRANT: begin
            release_c = !bus.req[owner_q] || timeout;
            if (release_c) begin
               state_d = TURN;
               gnt_d   = '0;
               busy_d  = 1'b0;
               ptr_d   = (owner_q == PW'(M - 1)) ? '0 : owner_q + PW'(1);
            end
         end
         // IDLE and TURN arbitrate the same way; TURN never lingers.
         default: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (any_req) begin
               state_d    = GRANT;
               gnt_d[win] = 1'b1;
               owner_d    = win;
               busy_d     = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.owner = owner_q;
   assign bus.busy  = busy_q;
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: bus-level model plus directed scenarios.
// Build with or without ARB_TIMEOUT_EN; expectations follow the define.
module tb_tri_bus_arbiter;
   localparam int N        = 3;
   localparam int M        = 4;
   localparam int MAX_HOLD = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   tri_bus_arbiter_if #(.M(M)) bus ();

   tri_bus_arbiter #(
      .N(N),
      .M(M),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Model: who holds the bus, for how long, and where the search starts.
   int m_owner = 0;
   int m_ptr   = 0;
   int m_hold  = 0;
   bit m_busy  = 1'b0;
   bit m_rel;
   bit m_found;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  = 1'b0;
         m_owner = 0;
         m_ptr   = 0;
         m_hold  = 0;
      end else if (m_busy) begin
         m_rel = !bus.req[m_owner];
`ifdef ARB_TIMEOUT_EN
         if (m_hold == MAX_HOLD) m_rel = 1'b1;
`endif
         if (m_rel) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % M;
         end else begin
            m_hold++;
         end
      end else begin
         m_found = 1'b0;
         for (int k = 0; k < M; k++) begin
            if (!m_found && bus.req[(m_ptr + k) % M]) begin
               m_found = 1'b1;
               m_owner = (m_ptr + k) % M;
            end
         end
         if (m_found) begin
            m_busy = 1'b1;
            m_hold = 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   logic [M-1:0] m_gnt;

   always @(negedge clk) begin
      m_gnt = m_busy ? (M'(1) << m_owner) : '0;
      check("cyc_gnt", 32'(bus.gnt), 32'(m_gnt));
      check("cyc_busy", 32'(bus.busy), 32'(m_busy));
      check("cyc_owner", 32'(bus.owner), 32'(m_owner));
      check("cyc_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
      check("cyc_busy_or", 32'(bus.busy), 32'(|bus.gnt));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [M-1:0] order [5];
   int           hi_cnt;
   logic [19:0]  hist;

   initial begin
      order[0] = 4'b0001;
      order[1] = 4'b0010;
      order[2] = 4'b0100;
      order[3] = 4'b1000;
      order[4] = 4'b0001;

      // 1: reset with everyone requesting
      bus.req = 4'b1111;
      #12;
      check("t1_rst_gnt", 32'(bus.gnt), 32'h0);
      check("t1_rst_busy", 32'(bus.busy), 32'h0);
      check("t1_rst_owner", 32'(bus.owner), 32'h0);
      rst_n = 1'b1;
      tick();
      check("t1_first_gnt", 32'(bus.gnt), 32'h1);
      bus.req = '0;
      tick();
      tick();

      // 2: single pulse from idle
      bus.req = 4'b0001;
      tick();
      check("t2_gnt", 32'(bus.gnt), 32'h1);
      bus.req = '0;
      tick();
      check("t2_rel", 32'(bus.gnt), 32'h0);
      tick();
      check("t2_idle_busy", 32'(bus.busy), 32'h0);

      // 3: two requesters, turnaround between them
      bus.req = 4'b1010;
      tick();
      check("t3_gnt1", 32'(bus.gnt), 32'h2);
      check("t3_own1", 32'(bus.owner), 32'h1);
      bus.req = 4'b1000;
      tick();
      check("t3_turn", 32'(bus.gnt), 32'h0);
      tick();
      check("t3_gnt3", 32'(bus.gnt), 32'h8);
      check("t3_own3", 32'(bus.owner), 32'h3);
      bus.req = '0;
      tick();
      tick();

      // 4: full rotation with re-assert during turnaround
      bus.req = 4'b1111;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("t4_order", 32'(bus.gnt), 32'(order[i]));
         tick();
         check("t4_hold", 32'(bus.gnt), 32'(order[i]));
         bus.req = 4'b1111 & ~order[i];
         tick();
         check("t4_gap", 32'(bus.gnt), 32'h0);
         bus.req = 4'b1111;
         tick();
      end
      bus.req = '0;
      tick();
      tick();

      // 5: lone requester held for 20 cycles
      bus.req = 4'b0001;
      tick();
      hi_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         hist[c] = bus.gnt[0];
         if (bus.gnt[0]) hi_cnt++;
         tick();
      end
`ifdef ARB_TIMEOUT_EN
      check("t5_hi_cnt", 32'(hi_cnt), 32'd18);
      check("t5_pattern", 32'(hist), 32'hDFEFF);
`else
      check("t5_hi_cnt", 32'(hi_cnt), 32'd20);
      check("t5_pattern", 32'(hist), 32'hFFFFF);
`endif
      bus.req = '0;
      tick();
      tick();

      // 6: asynchronous reset mid-grant, then pointer back at 0
      bus.req = 4'b0100;
      tick();
      check("t6_gnt", 32'(bus.gnt), 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_gnt", 32'(bus.gnt), 32'h0);
      check("t6_async_busy", 32'(bus.busy), 32'h0);
      tick();
      rst_n   = 1'b1;
      bus.req = 4'b0110;
      tick();
      check("t6_ptr0_gnt", 32'(bus.gnt), 32'h2);
      check("t6_ptr0_own", 32'(bus.owner), 32'h1);
      bus.req = '0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
